// File: rtl/mem_responder.sv
// Single-port byte-addressable memory slave with a fixed-latency valid/ready request/response handshake.
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned or reserved-size requests.
module mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS      = 64,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned ADDR_WIDTH = $clog2(WORDS);
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0]   mem_q [WORDS];

  logic                    accept_c, access_c, done_c, mem_we_c;
  logic [1:0]              cap_off_c, cap_size_c;
  logic                    cap_err_c;
  logic [4:0]              shift_c;
  logic [DATA_WIDTH-1:0]   size_mask_c, lane_mask_c, old_word_c, wr_word_c, rd_word_c;
  logic                    unused_addr_bits;

  assign accept_c = (state_q == IDLE) && req_valid && req_ready_q;
  assign access_c = (state_q == BUSY) && (cnt_q == '0);
  assign done_c   = (state_q == RESP) && rsp_valid_q && rsp_ready;
  assign mem_we_c = access_c && wr_q && !err_q;

  // Upper address bits are deliberately ignored so addresses wrap modulo WORDS*4.
  assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH+2];

  // Normalise the incoming access: lane offset, effective size and error flag.
  always_comb begin
    cap_off_c  = req_addr[1:0];
    cap_size_c = req_size;
    cap_err_c  = 1'b0;
    case (req_size)
      2'b00:   cap_off_c = req_addr[1:0];
      2'b01:   cap_off_c = {req_addr[1], 1'b0};
      default: begin
        cap_off_c  = 2'b00;
        cap_size_c = 2'b10;
      end
    endcase
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    case (req_size)
      2'b01:   cap_err_c = req_addr[0];
      2'b10:   cap_err_c = |req_addr[1:0];
      2'b11:   cap_err_c = 1'b1;
      default: cap_err_c = 1'b0;
    endcase
`endif
  end

  // Byte-lane merge for stores and right-aligned extract for loads.
  always_comb begin
    shift_c = {off_q, 3'b000};
    case (size_q)
      2'b00:   size_mask_c = DATA_WIDTH'(8'hFF);
      2'b01:   size_mask_c = DATA_WIDTH'(16'hFFFF);
      default: size_mask_c = '1;
    endcase
    lane_mask_c = size_mask_c << shift_c;
    old_word_c  = mem_q[idx_q];
    wr_word_c   = (old_word_c & ~lane_mask_c) | ((wdata_q & size_mask_c) << shift_c);
    rd_word_c   = (old_word_c >> shift_c) & size_mask_c;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = BUSY;
      BUSY:    if (access_c) state_d = RESP;
      RESP:    if (done_c)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and request capture; rsp_* only change on the edge entering RESP.
  always_comb begin
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    off_d       = off_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    if (accept_c) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      wr_d    = req_write;
      idx_d   = req_addr[ADDR_WIDTH+1:2];
      off_d   = cap_off_c;
      size_d  = cap_size_c;
      wdata_d = req_wdata;
      err_d   = cap_err_c;
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (access_c) begin
      rsp_rdata_d = (wr_q || err_q) ? '0 : rd_word_c;
      rsp_err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage; reset clears every word so an interrupted store never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[idx_q] <= wr_word_c;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter WORDS, default 64, storage depth in DATA_WIDTH words; ADDR_WIDTH = clog2(WORDS).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to rsp_valid; legal range 1..15.
REQ-004 SHALL have ports, in this order:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  DATA_WIDTH  byte address.
- req_size  input  2  access type: 00 byte, 01 half, 10 word, 11 reserved.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  DATA_WIDTH  load data, right-aligned, zero-extended.
- rsp_err  output  1  request was rejected; no memory effect.

Function
REQ-005 SHALL implement a three-state FSM:
- IDLE: req_ready=1; on req_valid&&req_ready, capture write, addr, size, wdata; load counter with LATENCY-1; go to BUSY.
- BUSY: decrement counter each cycle; at 0, perform the access and go to RESP.
- RESP: rsp_valid=1; hold all rsp_* outputs stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-006 SHALL assert req_ready only in IDLE; no new request is accepted in the cycle a response handshake completes.
REQ-007 SHALL assert rsp_valid exactly LATENCY cycles after the accept edge when rsp_ready is held 1, so one transaction takes LATENCY+1 cycles.
REQ-008 SHALL form the word index as addr[ADDR_WIDTH+1:2] and ignore higher address bits, so addresses wrap modulo WORDS*4.
REQ-009 SHALL use little-endian byte lanes:
- byte: lane addr[1:0].
- half: lanes {addr[1],0} and {addr[1],1}.
- word: all four lanes.
REQ-010 SHALL, on a store, modify only the addressed lanes with the low-order bytes of wdata, and return rsp_rdata=0.
REQ-011 SHALL, on a load, return the addressed lanes right-aligned in rsp_rdata with upper bits zero; sign extension is the initiator's job.
REQ-012 SHALL perform the memory read or write on the edge that enters RESP; a load therefore returns contents as of that edge.
REQ-013 SHALL ignore req_* inputs outside IDLE and ignore rsp_ready outside RESP.
REQ-014 SHALL initialise storage from no file; contents are defined only through stores or reset (REQ-016).

Reset
REQ-015 SHALL, while rst_n=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-016 SHALL clear every storage word to 0 on reset.
REQ-017 SHALL, on reset mid-transaction, abandon the transaction: no store is committed and no response is issued.
REQ-018 SHALL register req_ready and drive it to 1 on the first rising clk edge after rst_n deasserts.

Configuration
REQ-019 SHALL, with macro MEM_RESPONDER_ALIGN_CHECK_EN defined, detect these conditions at accept:
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- req_size=11.
Such a request completes the normal LATENCY timing with rsp_err=1, rsp_rdata=0, and leaves memory unchanged.
REQ-020 SHALL, with MEM_RESPONDER_ALIGN_CHECK_EN undefined:
- force rsp_err to constant 0;
- clear the misaligned low address bits (half: addr[0]=0; word: addr[1:0]=0);
- treat req_size=11 as word.

Verification
REQ-021 Reset, then store word 0xDEADBEEF at 0x8; load word at 0x8 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid exactly 2 cycles after accept.
REQ-022 After REQ-021, store byte 0x5A at 0xA, then load word at 0x8 -> 0xDE5ABEEF; load half at 0xA -> 0x0000DE5A; load byte at 0xB -> 0x000000DE.
REQ-023 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
REQ-024 Store word 0x11223344 at 0x100 (WORDS=64) -> a load word at 0x0 returns 0x11223344 (wrap-around).
REQ-025 With MEM_RESPONDER_ALIGN_CHECK_EN: store word at 0x6 -> rsp_err=1 and a load at 0x4 is unchanged. Without it: the same store writes word 0x4.
REQ-026 Pulse rst_n low while in BUSY on a store of 0xFFFFFFFF to 0x0 -> no response; after reset, a load at 0x0 returns 0.
